// File: rtl/vip_frame_ctrl_if.sv
// Video timing and threshold-configuration bus for the Sobel frame controller.
// The master drives the video strobes and config requests; the slave returns status.
interface vip_frame_ctrl_if;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic        cfg_valid;
    logic [7:0]  cfg_threshold;
    logic        cfg_ready;
    logic [7:0]  sobel_threshold;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_cnt;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken,
        output cfg_valid, cfg_threshold,
        input  cfg_ready, sobel_threshold,
        input  frame_start, frame_done, frame_err, frame_cnt
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken,
        input  cfg_valid, cfg_threshold,
        output cfg_ready, sobel_threshold,
        output frame_start, frame_done, frame_err, frame_cnt
    );
endinterface

// File: rtl/vip_frame_ctrl.sv
// Frame controller: tracks vsync/href framing, checks frame geometry and applies
// host threshold updates to the Sobel stage only at start of frame.
module vip_frame_ctrl #(
    parameter logic [9:0] IMG_HDISP   = 10'd640,
    parameter logic [9:0] IMG_VDISP   = 10'd480,
    parameter logic [7:0] THRESH_INIT = 8'd40
) (
    input  logic             clk,
    input  logic             rst,
    vip_frame_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned THR_W   = 8;
    localparam int unsigned FCNT_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        FRAME    = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic                vsync_q, href_q;
    logic                vs_rise, vs_fall, href_rise, href_fall;
    logic                sof, in_frame;

    logic [CNT_W-1:0]    pix_cnt_q,  pix_cnt_d;
    logic [CNT_W-1:0]    line_cnt_q, line_cnt_d;
    logic                err_acc_q,  err_acc_d;
    logic                pending_q,  pending_d;
    logic [THR_W-1:0]    pend_val_q, pend_val_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic [THR_W-1:0]    thresh_q,   thresh_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q,  frame_done_d;
    logic                frame_err_q,   frame_err_d;
    logic [FCNT_W-1:0]   frame_cnt_q,   frame_cnt_d;

    // Edges compare the live input against its one-cycle registered copy
    assign vs_rise   =  bus.per_frame_vsync & ~vsync_q;
    assign vs_fall   = ~bus.per_frame_vsync &  vsync_q;
    assign href_rise =  bus.per_frame_href  & ~href_q;
    assign href_fall = ~bus.per_frame_href  &  href_q;

    assign sof      = (state_q == WAIT_SOF) & vs_rise;
    assign in_frame = (state_q == FRAME);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE refuses start-of-frame so a frame already running at reset is skipped
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (!bus.per_frame_vsync) state_d = WAIT_SOF;
            WAIT_SOF: if (vs_rise)              state_d = FRAME;
            FRAME:    if (vs_fall)              state_d = WAIT_SOF;
            default:                            state_d = IDLE;
        endcase
    end

    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        err_acc_d     = err_acc_q;
        pending_d     = pending_q;
        pend_val_d    = pend_val_q;
        thresh_d      = thresh_q;
        frame_err_d   = frame_err_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = sof;
        frame_done_d  = in_frame & vs_fall;

        if (sof) begin
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            err_acc_d  = 1'b0;
        end else if (in_frame) begin
            // The rising-edge cycle already carries the first pixel of the line
            if (href_rise) begin
                pix_cnt_d = CNT_W'(bus.per_frame_clken);
            end else if (bus.per_frame_href && bus.per_frame_clken && (pix_cnt_q != CNT_MAX)) begin
                pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end

            if (href_fall) begin
                if (pix_cnt_q != IMG_HDISP) err_acc_d = 1'b1;
                if (line_cnt_q != CNT_MAX)  line_cnt_d = line_cnt_q + CNT_W'(1);
            end

            // Uses the *_d values so a coincident href fall is folded in first
            if (vs_fall) begin
                frame_err_d = err_acc_d | (line_cnt_d != IMG_VDISP);
                frame_cnt_d = frame_cnt_q + FCNT_W'(1);
            end
        end

        if (sof && pending_q) begin
            thresh_d  = pend_val_q;
            pending_d = 1'b0;
        end

        // cfg_ready_q is ~pending_q, so this never overlaps the apply above
        if (bus.cfg_valid && cfg_ready_q) begin
            pending_d  = 1'b1;
            pend_val_d = bus.cfg_threshold;
        end

        cfg_ready_d = ~pending_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            err_acc_q     <= 1'b0;
            pending_q     <= 1'b0;
            pend_val_q    <= '0;
            cfg_ready_q   <= 1'b1;
            thresh_q      <= THRESH_INIT;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            vsync_q       <= bus.per_frame_vsync;
            href_q        <= bus.per_frame_href;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            err_acc_q     <= err_acc_d;
            pending_q     <= pending_d;
            pend_val_q    <= pend_val_d;
            cfg_ready_q   <= cfg_ready_d;
            thresh_q      <= thresh_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.cfg_ready       = cfg_ready_q;
    assign bus.sobel_threshold = thresh_q;
    assign bus.frame_start     = frame_start_q;
    assign bus.frame_done      = frame_done_q;
    assign bus.frame_err       = frame_err_q;
    assign bus.frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_vip_frame_ctrl.sv
// Directed bench for vip_frame_ctrl: an 8x4 instance for framing/config/reset
// scenarios and a 1x1 instance driven through 65536 frames for the counter wrap.
module tb_vip_frame_ctrl;

    localparam int unsigned H = 8;
    localparam int unsigned V = 4;

    logic clk = 1'b0;
    logic rst;
    logic w_rst;

    int n_cmp = 0;
    int n_bad = 0;
    int fs_cnt = 0;
    int fd_cnt = 0;
    int fd_before;

    always #5 clk = ~clk;

    vip_frame_ctrl_if vif ();
    vip_frame_ctrl_if wif ();

    vip_frame_ctrl #(
        .IMG_HDISP   (10'(H)),
        .IMG_VDISP   (10'(V)),
        .THRESH_INIT (8'd40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    vip_frame_ctrl #(
        .IMG_HDISP   (10'd1),
        .IMG_VDISP   (10'd1),
        .THRESH_INIT (8'd40)
    ) wdut (
        .clk (clk),
        .rst (w_rst),
        .bus (wif)
    );

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (vif.frame_start === 1'b1) fs_cnt <= fs_cnt + 1;
        if (vif.frame_done  === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_begin();
        vif.per_frame_vsync = 1'b1;
        tick(1);
    endtask

    // Drives one line of npix pixels; drop=0 leaves href high for a coincident end
    task automatic frame_line(input int npix, input bit drop);
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b1;
        tick(npix);
        if (drop) begin
            vif.per_frame_href  = 1'b0;
            vif.per_frame_clken = 1'b0;
            tick(2);
        end
    endtask

    task automatic frame_end();
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.per_frame_vsync = 1'b0;
        tick(1);
    endtask

    task automatic full_frame(input int short_line);
        tick(2);
        frame_begin();
        tick(2);
        for (int l = 0; l < int'(V); l++) frame_line((l == short_line) ? int'(H) - 1 : int'(H), 1'b1);
        frame_end();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_thresh"},  32'(vif.sobel_threshold), 32'd40);
        check({pfx, "_ready"},   32'(vif.cfg_ready),       32'd1);
        check({pfx, "_start"},   32'(vif.frame_start),     32'd0);
        check({pfx, "_done"},    32'(vif.frame_done),      32'd0);
        check({pfx, "_err"},     32'(vif.frame_err),       32'd0);
        check({pfx, "_cnt"},     32'(vif.frame_cnt),       32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        w_rst = 1'b1;
        vif.per_frame_vsync = 1'b0;
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        vif.cfg_valid       = 1'b0;
        vif.cfg_threshold   = 8'd0;
        wif.per_frame_vsync = 1'b0;
        wif.per_frame_href  = 1'b0;
        wif.per_frame_clken = 1'b0;
        wif.cfg_valid       = 1'b0;
        wif.cfg_threshold   = 8'd0;
        tick(3);
        check_reset_outputs("por");
        rst   = 1'b0;
        w_rst = 1'b0;
        tick(2);

        // Nominal frames
        for (int f = 1; f <= 3; f++) begin
            full_frame(-1);
            check("nom_done", 32'(vif.frame_done), 32'd1);
            check("nom_err",  32'(vif.frame_err),  32'd0);
            check("nom_cnt",  32'(vif.frame_cnt),  32'(f));
        end
        tick(2);
        check("nom_done_pulses",  32'(fd_cnt), 32'd3);
        check("nom_start_pulses", 32'(fs_cnt), 32'd3);

        // Short line, error held across the gap, then cleared by a good frame
        full_frame(1);
        check("short_err", 32'(vif.frame_err), 32'd1);
        check("short_cnt", 32'(vif.frame_cnt), 32'd4);
        tick(3);
        check("short_err_hold", 32'(vif.frame_err), 32'd1);
        full_frame(-1);
        check("good_err", 32'(vif.frame_err), 32'd0);
        check("good_cnt", 32'(vif.frame_cnt), 32'd5);

        // Mid-frame config, second request while pending is ignored
        tick(2);
        frame_begin();
        check("cfg_sof_pulse", 32'(vif.frame_start), 32'd1);
        tick(2);
        frame_line(int'(H), 1'b1);
        vif.cfg_valid     = 1'b1;
        vif.cfg_threshold = 8'd80;
        tick(1);
        vif.cfg_valid = 1'b0;
        check("cfg_ready_low", 32'(vif.cfg_ready),       32'd0);
        check("cfg_not_yet",   32'(vif.sobel_threshold), 32'd40);
        frame_line(int'(H), 1'b1);
        vif.cfg_valid     = 1'b1;
        vif.cfg_threshold = 8'd99;
        tick(2);
        vif.cfg_valid = 1'b0;
        check("cfg_second_ready", 32'(vif.cfg_ready), 32'd0);
        frame_line(int'(H), 1'b1);
        frame_line(int'(H), 1'b1);
        frame_end();
        check("cfg_hold_eof",  32'(vif.sobel_threshold), 32'd40);
        check("cfg_frame_cnt", 32'(vif.frame_cnt),       32'd6);
        tick(2);
        frame_begin();
        check("cfg_applied",    32'(vif.sobel_threshold), 32'd80);
        check("cfg_ready_back", 32'(vif.cfg_ready),       32'd1);
        tick(2);
        for (int l = 0; l < int'(V) - 1; l++) frame_line(int'(H), 1'b1);
        frame_line(int'(H), 1'b0);
        frame_end();
        check("coinc_href_done", 32'(vif.frame_done), 32'd1);
        check("coinc_href_err",  32'(vif.frame_err),  32'd0);
        check("coinc_href_cnt",  32'(vif.frame_cnt),  32'd7);
        check("cfg_ignored_99",  32'(vif.sobel_threshold), 32'd80);

        // Config transfer in the same cycle as the vsync rising edge
        tick(2);
        vif.cfg_valid       = 1'b1;
        vif.cfg_threshold   = 8'd120;
        vif.per_frame_vsync = 1'b1;
        tick(1);
        vif.cfg_valid = 1'b0;
        check("sofcfg_start",  32'(vif.frame_start),     32'd1);
        check("sofcfg_thresh", 32'(vif.sobel_threshold), 32'd80);
        check("sofcfg_ready",  32'(vif.cfg_ready),       32'd0);
        tick(2);
        for (int l = 0; l < int'(V); l++) frame_line(int'(H), 1'b1);
        frame_end();
        check("sofcfg_keep", 32'(vif.sobel_threshold), 32'd80);
        full_frame(-1);
        check("sofcfg_next",  32'(vif.sobel_threshold), 32'd120);
        check("sofcfg_cnt",   32'(vif.frame_cnt),       32'd9);

        // Reset mid-frame with an update pending
        tick(2);
        frame_begin();
        tick(2);
        frame_line(int'(H), 1'b1);
        frame_line(int'(H), 1'b1);
        vif.cfg_valid     = 1'b1;
        vif.cfg_threshold = 8'd200;
        tick(1);
        vif.cfg_valid = 1'b0;
        check("rst_pend_ready", 32'(vif.cfg_ready), 32'd0);
        vif.per_frame_href  = 1'b1;
        vif.per_frame_clken = 1'b1;
        tick(3);
        rst = 1'b1;
        #2;
        check_reset_outputs("midrst");
        tick(2);
        rst = 1'b0;
        fd_before = fd_cnt;
        tick(int'(H) - 3);
        vif.per_frame_href  = 1'b0;
        vif.per_frame_clken = 1'b0;
        tick(2);
        frame_line(int'(H), 1'b1);
        frame_end();
        tick(2);
        check("rst_tail_no_done", 32'(fd_cnt),        32'(fd_before));
        check("rst_tail_cnt",     32'(vif.frame_cnt), 32'd0);
        full_frame(-1);
        check("rst_next_done",   32'(vif.frame_done),      32'd1);
        check("rst_next_cnt",    32'(vif.frame_cnt),       32'd1);
        check("rst_next_err",    32'(vif.frame_err),       32'd0);
        check("rst_pend_gone",   32'(vif.sobel_threshold), 32'd40);

        // Counter wrap on the 1x1 instance: two cycles per frame
        for (int i = 0; i < 65535; i++) begin
            wif.per_frame_vsync = 1'b1;
            tick(1);
            wif.per_frame_vsync = 1'b0;
            tick(1);
        end
        check("wrap_pre", 32'(wif.frame_cnt), 32'h0000_FFFF);
        wif.per_frame_vsync = 1'b1;
        tick(1);
        wif.per_frame_vsync = 1'b0;
        tick(1);
        check("wrap_done", 32'(wif.frame_done), 32'd1);
        check("wrap_cnt",  32'(wif.frame_cnt),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
